hit_capture: RTL and testbench

Front-end stage that feeds the play-mode datapath. It turns raw note keys and octave buttons into discrete hit records {clock, octave, note, length}.
- Debounces inputs, tracks the current octave, times each key hold in length units, and emits one record per completed press with a single-cycle valid strobe.
- Downstream, the sound and scoring logic consume the record.

---
 rtl/hit_capture_pkg.sv | 28 ++
 rtl/hit_capture_if.sv | 13 +
 rtl/hit_capture_debounce.sv | 45 ++++
 rtl/hit_capture.sv | 207 ++++++++++++++++++++
 tb/tb_hit_capture.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_capture_pkg.sv
// Shared widths, octave codes and FSM encodings for the hit_capture front end.
package hit_capture_pkg;

  localparam int NOTE_KEY_BITS = 7;
  localparam int NOTE_BITS     = 3;
  localparam int OCTAVE_BITS   = 2;
  localparam int LENGTH_BITS   = 3;
  localparam int CLOCK_BITS    = 32;

  localparam logic [OCTAVE_BITS-1:0] OCT_LOW  = 2'd0;
  localparam logic [OCTAVE_BITS-1:0] OCT_MID  = 2'd1;
  localparam logic [OCTAVE_BITS-1:0] OCT_HIGH = 2'd2;

  localparam logic [1:0] HC_IDLE  = 2'd0;
  localparam logic [1:0] HC_PRESS = 2'd1;
  localparam logic [1:0] HC_EMIT  = 2'd2;

  // Lowest pressed key wins; 0 means no key (rest).
  function automatic logic [NOTE_BITS-1:0] sel_note(input logic [NOTE_KEY_BITS-1:0] keys);
    logic [NOTE_BITS-1:0] n;
    n = 3'd0;
    for (int i = NOTE_KEY_BITS - 1; i >= 0; i--) begin
      if (keys[i]) n = NOTE_BITS'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/hit_capture_if.sv
// Hit record bus: one-cycle valid strobe plus the {clock, octave, note, length} record.
interface hit_capture_if;
  import hit_capture_pkg::*;

  logic                   hit_valid;
  logic [CLOCK_BITS-1:0]  hit_clock;
  logic [OCTAVE_BITS-1:0] hit_octave;
  logic [NOTE_BITS-1:0]   hit_note;
  logic [LENGTH_BITS-1:0] hit_length;

  modport master (output hit_valid, hit_clock, hit_octave, hit_note, hit_length);
  modport slave  (input  hit_valid, hit_clock, hit_octave, hit_note, hit_length);
endinterface

// File: rtl/hit_capture_debounce.sv
// Vector debouncer: clean follows raw once raw has been stable for CYCLES samples.
module hit_capture_debounce #(
  parameter int WIDTH  = 7,
  parameter int CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] clean_o
);
  localparam int               CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] last_q, clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stability counter restarts on any change versus the previous raw sample.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (raw_i != last_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      clean_d = raw_i;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Sample raw and hold the filtered vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= {WIDTH{1'b0}};
      clean_q <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      last_q  <= raw_i;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;
endmodule

// File: rtl/hit_capture.sv
// Turns debounced note keys and octave buttons into timed hit records.
// Optional HIT_REST_EN: gaps of at least one unit between presses produce a rest record.
module hit_capture
  import hit_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int UNIT_CYCLES     = 12500000,
  parameter int MAX_LENGTH      = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     oct_up_i,
  input  logic                     oct_down_i,
  input  logic [NOTE_KEY_BITS-1:0] note_key_i,
  input  logic [CLOCK_BITS-1:0]    system_clock_i,
  hit_capture_if.master            hit_o,
  output logic [OCTAVE_BITS-1:0]   octave_o,
  output logic                     holding_o
);
  localparam int                     UNIT_W    = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UNIT_W-1:0]      UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [UNIT_W-1:0]      UNIT_ONE  = UNIT_W'(1);
  localparam logic [LENGTH_BITS-1:0] MAX_LEN   = LENGTH_BITS'(MAX_LENGTH);
  localparam logic [LENGTH_BITS-1:0] LEN_ONE   = LENGTH_BITS'(1);

  logic [NOTE_KEY_BITS-1:0] keys_clean_s;
  logic [1:0]               btn_clean_s;
  logic [NOTE_BITS-1:0]     sel_s;
  logic                     up_s, dn_s, wrap_s;
  logic [UNIT_W-1:0]        cyc_inc_s;
  logic [LENGTH_BITS-1:0]   units_inc_s, len_s;

  logic [1:0]               btn_prev_q;
  logic [OCTAVE_BITS-1:0]   octave_q, octave_d;
  logic [1:0]               state_q, state_d;
  logic [NOTE_BITS-1:0]     note_q, note_d;
  logic [OCTAVE_BITS-1:0]   poct_q, poct_d;
  logic [CLOCK_BITS-1:0]    pclk_q, pclk_d;
  logic [UNIT_W-1:0]        cyc_q, cyc_d;
  logic [LENGTH_BITS-1:0]   units_q, units_d;
  logic                     hv_q, hv_d;
  logic [CLOCK_BITS-1:0]    hclk_q, hclk_d;
  logic [OCTAVE_BITS-1:0]   hoct_q, hoct_d;
  logic [NOTE_BITS-1:0]     hnote_q, hnote_d;
  logic [LENGTH_BITS-1:0]   hlen_q, hlen_d;
`ifdef HIT_REST_EN
  logic                     gap_q, gap_d;
`endif

  hit_capture_debounce #(.WIDTH(NOTE_KEY_BITS), .CYCLES(DEBOUNCE_CYCLES)) u_keys (
    .clk(clk), .rst_n(rst_n), .raw_i(note_key_i), .clean_o(keys_clean_s));

  hit_capture_debounce #(.WIDTH(2), .CYCLES(DEBOUNCE_CYCLES)) u_btns (
    .clk(clk), .rst_n(rst_n), .raw_i({oct_down_i, oct_up_i}), .clean_o(btn_clean_s));

  // Octave tracking and unit timing; the length includes this cycle's wrap.
  always_comb begin
    sel_s       = sel_note(keys_clean_s);
    up_s        = btn_clean_s[0] & ~btn_prev_q[0];
    dn_s        = btn_clean_s[1] & ~btn_prev_q[1];
    wrap_s      = (cyc_q == UNIT_LAST);
    cyc_inc_s   = wrap_s ? {UNIT_W{1'b0}} : cyc_q + UNIT_ONE;
    units_inc_s = (wrap_s && units_q != MAX_LEN) ? units_q + LEN_ONE : units_q;
    len_s       = (units_inc_s == {LENGTH_BITS{1'b0}}) ? LEN_ONE : units_inc_s;
    if (!en_i) begin
      octave_d = OCT_MID;
    end else if (up_s && !dn_s && octave_q != OCT_HIGH) begin
      octave_d = octave_q + 2'd1;
    end else if (dn_s && !up_s && octave_q != OCT_LOW) begin
      octave_d = octave_q - 2'd1;
    end else begin
      octave_d = octave_q;
    end
  end

  // Press FSM and record capture.
  always_comb begin
    state_d = state_q;  note_d  = note_q;  poct_d = poct_q;  pclk_d = pclk_q;
    cyc_d   = cyc_q;    units_d = units_q; hv_d   = 1'b0;
    hclk_d  = hclk_q;   hoct_d  = hoct_q;  hnote_d = hnote_q; hlen_d = hlen_q;
`ifdef HIT_REST_EN
    gap_d   = gap_q;
`endif
    if (!en_i) begin
      state_d = HC_IDLE;
      cyc_d   = {UNIT_W{1'b0}};
      units_d = {LENGTH_BITS{1'b0}};
`ifdef HIT_REST_EN
      gap_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        HC_IDLE: begin
`ifdef HIT_REST_EN
          cyc_d   = cyc_inc_s;
          units_d = units_inc_s;
`else
          cyc_d   = {UNIT_W{1'b0}};
          units_d = {LENGTH_BITS{1'b0}};
`endif
          if (sel_s != 3'd0) begin
`ifdef HIT_REST_EN
            if (gap_q && units_inc_s != {LENGTH_BITS{1'b0}}) begin
              hv_d    = 1'b1;
              hclk_d  = pclk_q;
              hoct_d  = octave_q;
              hnote_d = 3'd0;
              hlen_d  = units_inc_s;
            end else begin
              hv_d    = 1'b0;
            end
            gap_d   = 1'b0;
`endif
            state_d = HC_PRESS;
            note_d  = sel_s;
            poct_d  = octave_q;
            pclk_d  = system_clock_i;
            cyc_d   = {UNIT_W{1'b0}};
            units_d = {LENGTH_BITS{1'b0}};
          end else begin
            state_d = HC_IDLE;
          end
        end
        HC_PRESS: begin
          cyc_d   = cyc_inc_s;
          units_d = units_inc_s;
          if (sel_s != note_q) begin
            state_d = HC_EMIT;
            hv_d    = 1'b1;
            hclk_d  = pclk_q;
            hoct_d  = poct_q;
            hnote_d = note_q;
            hlen_d  = len_s;
          end else begin
            state_d = HC_PRESS;
          end
        end
        HC_EMIT: begin
          cyc_d   = {UNIT_W{1'b0}};
          units_d = {LENGTH_BITS{1'b0}};
          if (sel_s != 3'd0) begin
            state_d = HC_PRESS;
            note_d  = sel_s;
            poct_d  = octave_q;
            pclk_d  = system_clock_i;
          end else begin
            // The press clock register doubles as the gap start time.
            state_d = HC_IDLE;
            pclk_d  = system_clock_i;
`ifdef HIT_REST_EN
            gap_d   = 1'b1;
`endif
          end
        end
        default: state_d = HC_IDLE;
      endcase
    end
  end

  // State and record registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 2'b00;
      octave_q   <= OCT_MID;
      state_q    <= HC_IDLE;
      note_q     <= 3'd0;
      poct_q     <= OCT_MID;
      pclk_q     <= {CLOCK_BITS{1'b0}};
      cyc_q      <= {UNIT_W{1'b0}};
      units_q    <= {LENGTH_BITS{1'b0}};
      hv_q       <= 1'b0;
      hclk_q     <= {CLOCK_BITS{1'b0}};
      hoct_q     <= OCT_MID;
      hnote_q    <= 3'd0;
      hlen_q     <= {LENGTH_BITS{1'b0}};
`ifdef HIT_REST_EN
      gap_q      <= 1'b0;
`endif
    end else begin
      btn_prev_q <= btn_clean_s;
      octave_q   <= octave_d;
      state_q    <= state_d;
      note_q     <= note_d;
      poct_q     <= poct_d;
      pclk_q     <= pclk_d;
      cyc_q      <= cyc_d;
      units_q    <= units_d;
      hv_q       <= hv_d;
      hclk_q     <= hclk_d;
      hoct_q     <= hoct_d;
      hnote_q    <= hnote_d;
      hlen_q     <= hlen_d;
`ifdef HIT_REST_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign hit_o.hit_valid  = hv_q;
  assign hit_o.hit_clock  = hclk_q;
  assign hit_o.hit_octave = hoct_q;
  assign hit_o.hit_note   = hnote_q;
  assign hit_o.hit_length = hlen_q;
  assign octave_o         = octave_q;
  assign holding_o        = (state_q == HC_PRESS);
endmodule

// File: tb/tb_hit_capture.sv
// Directed bench for hit_capture with short debounce/unit timing.
module tb_hit_capture;
  import hit_capture_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, oct_up = 1'b0, oct_down = 1'b0;
  logic [6:0]  note_key = 7'd0;
  logic [31:0] system_clock = 32'd0;
  logic [1:0]  octave;
  logic        holding;
  int          total = 0, bad = 0;

  typedef struct packed {
    logic [31:0] c;
    logic [1:0]  o;
    logic [2:0]  n;
    logic [2:0]  l;
  } rec_t;
  rec_t recs[$];

  hit_capture_if hif();

  hit_capture #(.DEBOUNCE_CYCLES(4), .UNIT_CYCLES(10), .MAX_LENGTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .oct_up_i(oct_up), .oct_down_i(oct_down),
    .note_key_i(note_key), .system_clock_i(system_clock), .hit_o(hif),
    .octave_o(octave), .holding_o(holding));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && hif.hit_valid)
      recs.push_back({hif.hit_clock, hif.hit_octave, hif.hit_note, hif.hit_length});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; note_key = 7'd0; oct_up = 1'b0; oct_down = 1'b0;
    system_clock = 32'd0;
    cyc(2);
    rst_n = 1'b1; en = 1'b1;
    cyc(1);
    recs.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    cyc(2);
    total++; if (hif.hit_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", hif.hit_valid); end
    total++; if (hif.hit_clock !== 32'd0) begin bad++; $display("FAIL rst_clock got=%0d exp=0", hif.hit_clock); end
    total++; if (hif.hit_octave !== 2'd1) begin bad++; $display("FAIL rst_hoct got=%0d exp=1", hif.hit_octave); end
    total++; if (hif.hit_note !== 3'd0) begin bad++; $display("FAIL rst_note got=%0d exp=0", hif.hit_note); end
    total++; if (hif.hit_length !== 3'd0) begin bad++; $display("FAIL rst_len got=%0d exp=0", hif.hit_length); end
    total++; if (octave !== 2'd1) begin bad++; $display("FAIL rst_octave got=%0d exp=1", octave); end
    total++; if (holding !== 1'b0) begin bad++; $display("FAIL rst_holding got=%0b exp=0", holding); end
  endtask

  task automatic test_basic_press();
    rec_t r;
    do_reset();
    system_clock = 32'd100;
    note_key = 7'b0000100;
    cyc(5);
    total++; if (holding !== 1'b0) begin bad++; $display("FAIL basic_early holding=%0b exp=0", holding); end
    cyc(1);
    total++; if (holding !== 1'b1) begin bad++; $display("FAIL basic_accept holding=%0b exp=1", holding); end
    system_clock = 32'd101;
    cyc(29);
    note_key = 7'd0;
    cyc(5);
    total++; if (hif.hit_valid !== 1'b0) begin bad++; $display("FAIL basic_prevalid got=%0b exp=0", hif.hit_valid); end
    cyc(1);
    total++; if (hif.hit_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", hif.hit_valid); end
    total++; if (holding !== 1'b0) begin bad++; $display("FAIL basic_release holding=%0b exp=0", holding); end
    cyc(1);
    total++; if (hif.hit_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0b exp=0", hif.hit_valid); end
    total++; if (recs.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", recs.size()); end
    if (recs.size() > 0) r = recs[0]; else r = '0;
    total++; if (r !== {32'd100, 2'd1, 3'd3, 3'd3}) begin
      bad++; $display("FAIL basic_rec got=%0d/%0d/%0d/%0d exp=100/1/3/3", r.c, r.o, r.n, r.l);
    end
  endtask

  task automatic test_glitch_octave();
    rec_t r;
    logic [1:0] exp_oct [0:5];
    exp_oct[0] = 2'd2; exp_oct[1] = 2'd2; exp_oct[2] = 2'd2;
    exp_oct[3] = 2'd1; exp_oct[4] = 2'd0; exp_oct[5] = 2'd0;
    do_reset();
    note_key = 7'b0000001;
    cyc(2);
    note_key = 7'd0;
    cyc(10);
    total++; if (holding !== 1'b0) begin bad++; $display("FAIL glitch_holding got=%0b exp=0", holding); end
    total++; if (recs.size() != 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", recs.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < 3) oct_up = 1'b1; else oct_down = 1'b1;
      cyc(6);
      oct_up = 1'b0; oct_down = 1'b0;
      cyc(8);
      total++; if (octave !== exp_oct[i]) begin bad++; $display("FAIL octave_step%0d got=%0d exp=%0d", i, octave, exp_oct[i]); end
    end
    note_key = 7'b0000010;
    cyc(6);
    note_key = 7'd0;
    cyc(8);
    total++; if (recs.size() != 1) begin bad++; $display("FAIL lowoct_count got=%0d exp=1", recs.size()); end
    if (recs.size() > 0) r = recs[0]; else r = '0;
    total++; if (r !== {32'd0, 2'd0, 3'd2, 3'd1}) begin
      bad++; $display("FAIL lowoct_rec got=%0d/%0d/%0d/%0d exp=0/0/2/1", r.c, r.o, r.n, r.l);
    end
  endtask

  task automatic test_long_short();
    rec_t r;
    do_reset();
    note_key = 7'b0000010;
    cyc(200);
    note_key = 7'd0;
    cyc(8);
    total++; if (recs.size() != 1) begin bad++; $display("FAIL long_count got=%0d exp=1", recs.size()); end
    if (recs.size() > 0) r = recs[0]; else r = '0;
    total++; if (r.l !== 3'd7 || r.n !== 3'd2) begin
      bad++; $display("FAIL long_rec got=len%0d note%0d exp=len7 note2", r.l, r.n);
    end
    note_key = 7'b0000010;
    cyc(9);
    note_key = 7'd0;
    cyc(8);
    total++; if (recs.size() != 2) begin bad++; $display("FAIL short_count got=%0d exp=2", recs.size()); end
    if (recs.size() > 1) r = recs[1]; else r = '0;
    total++; if (r.l !== 3'd1 || r.n !== 3'd2) begin
      bad++; $display("FAIL short_rec got=len%0d note%0d exp=len1 note2", r.l, r.n);
    end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    do_reset();
    system_clock = 32'd300;
    note_key = 7'b0000001;
    cyc(25);
    note_key = 7'b0010000;
    system_clock = 32'd400;
    cyc(5);
    total++; if (hif.hit_valid !== 1'b0 || holding !== 1'b1) begin
      bad++; $display("FAIL b2b_pre got=v%0b h%0b exp=v0 h1", hif.hit_valid, holding);
    end
    cyc(1);
    total++; if (hif.hit_valid !== 1'b1 || hif.hit_note !== 3'd1 || hif.hit_length !== 3'd2 || hif.hit_clock !== 32'd300) begin
      bad++; $display("FAIL b2b_first got=v%0b n%0d l%0d c%0d exp=v1 n1 l2 c300",
                      hif.hit_valid, hif.hit_note, hif.hit_length, hif.hit_clock);
    end
    total++; if (holding !== 1'b0) begin bad++; $display("FAIL b2b_emit holding=%0b exp=0", holding); end
    cyc(1);
    total++; if (holding !== 1'b1 || hif.hit_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_relatch got=h%0b v%0b exp=h1 v0", holding, hif.hit_valid);
    end
    cyc(18);
    note_key = 7'd0;
    cyc(10);
    total++; if (recs.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", recs.size()); end
    if (recs.size() > 1) r = recs[1]; else r = '0;
    total++; if (r !== {32'd400, 2'd1, 3'd5, 3'd2}) begin
      bad++; $display("FAIL b2b_second got=%0d/%0d/%0d/%0d exp=400/1/5/2", r.c, r.o, r.n, r.l);
    end
  endtask

  task automatic test_enable();
    rec_t r;
    do_reset();
    oct_up = 1'b1;
    cyc(6);
    oct_up = 1'b0;
    cyc(8);
    total++; if (octave !== 2'd2) begin bad++; $display("FAIL en_octup got=%0d exp=2", octave); end
    note_key = 7'b0001000;
    cyc(6);
    total++; if (holding !== 1'b1) begin bad++; $display("FAIL en_press holding=%0b exp=1", holding); end
    cyc(15);
    en = 1'b0;
    cyc(1);
    total++; if (holding !== 1'b0 || octave !== 2'd1 || hif.hit_valid !== 1'b0) begin
      bad++; $display("FAIL en_drop got=h%0b o%0d v%0b exp=h0 o1 v0", holding, octave, hif.hit_valid);
    end
    cyc(5);
    total++; if (recs.size() != 0) begin bad++; $display("FAIL en_norec got=%0d exp=0", recs.size()); end
    en = 1'b1;
    cyc(1);
    total++; if (holding !== 1'b1) begin bad++; $display("FAIL en_rise holding=%0b exp=1", holding); end
    note_key = 7'd0;
    cyc(8);
    total++; if (recs.size() != 1) begin bad++; $display("FAIL en_count got=%0d exp=1", recs.size()); end
    if (recs.size() > 0) r = recs[0]; else r = '0;
    total++; if (r.n !== 3'd4 || r.o !== 2'd1) begin
      bad++; $display("FAIL en_rec got=n%0d o%0d exp=n4 o1", r.n, r.o);
    end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    oct_up = 1'b1;
    cyc(6);
    oct_up = 1'b0;
    cyc(8);
    system_clock = 32'd55;
    note_key = 7'b0000100;
    cyc(6);
    note_key = 7'd0;
    cyc(8);
    total++; if (hif.hit_note !== 3'd3 || hif.hit_octave !== 2'd2) begin
      bad++; $display("FAIL rmid_setup got=n%0d o%0d exp=n3 o2", hif.hit_note, hif.hit_octave);
    end
    note_key = 7'b1000000;
    system_clock = 32'd77;
    cyc(10);
    total++; if (holding !== 1'b1) begin bad++; $display("FAIL rmid_press holding=%0b exp=1", holding); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (hif.hit_valid !== 1'b0 || hif.hit_clock !== 32'd0 || hif.hit_octave !== 2'd1 ||
                 hif.hit_note !== 3'd0 || hif.hit_length !== 3'd0 || octave !== 2'd1 || holding !== 1'b0) begin
      bad++; $display("FAIL rmid_clear got=v%0b c%0d ho%0d n%0d l%0d o%0d h%0b exp=0/0/1/0/0/1/0",
                      hif.hit_valid, hif.hit_clock, hif.hit_octave, hif.hit_note, hif.hit_length, octave, holding);
    end
    note_key = 7'd0;
    rst_n = 1'b1;
    cyc(10);
    total++; if (recs.size() != 1 || holding !== 1'b0) begin
      bad++; $display("FAIL rmid_norec got=cnt%0d h%0b exp=cnt1 h0", recs.size(), holding);
    end
  endtask

  task automatic test_rest_gap();
    rec_t r;
    do_reset();
    system_clock = 32'd10;
    note_key = 7'b0001000;
    cyc(10);
    note_key = 7'd0;
    system_clock = 32'd500;
    cyc(25);
    system_clock = 32'd600;
    note_key = 7'b1000000;
    cyc(10);
    note_key = 7'd0;
    cyc(10);
`ifdef HIT_REST_EN
    total++; if (recs.size() != 3) begin bad++; $display("FAIL rest_count got=%0d exp=3", recs.size()); end
    if (recs.size() > 1) r = recs[1]; else r = '0;
    total++; if (r !== {32'd500, 2'd1, 3'd0, 3'd2}) begin
      bad++; $display("FAIL rest_rec got=%0d/%0d/%0d/%0d exp=500/1/0/2", r.c, r.o, r.n, r.l);
    end
    if (recs.size() > 2) r = recs[2]; else r = '0;
`else
    total++; if (recs.size() != 2) begin bad++; $display("FAIL rest_count got=%0d exp=2", recs.size()); end
    if (recs.size() > 1) r = recs[1]; else r = '0;
`endif
    total++; if (r !== {32'd600, 2'd1, 3'd7, 3'd1}) begin
      bad++; $display("FAIL rest_note got=%0d/%0d/%0d/%0d exp=600/1/7/1", r.c, r.o, r.n, r.l);
    end
    if (recs.size() > 0) r = recs[0]; else r = '0;
    total++; if (r !== {32'd10, 2'd1, 3'd4, 3'd1}) begin
      bad++; $display("FAIL rest_first got=%0d/%0d/%0d/%0d exp=10/1/4/1", r.c, r.o, r.n, r.l);
    end
  endtask

  initial begin
    test_reset();
    test_basic_press();
    test_glitch_octave();
    test_long_short();
    test_back_to_back();
    test_enable();
    test_reset_mid_press();
    test_rest_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
